// File: rtl/elevador_pkg.sv
// Shared types and constants for the elevator call reader.
// Holds the reader FSM encoding, floor-code sizing and a floor-mask helper.
package elevador_pkg;

  localparam int N_ANDARES_MAX = 4;
  localparam int LARGURA_ANDAR = 2;

  typedef enum logic [1:0] {
    OCIOSO,
    SUBINDO,
    DESCENDO,
    ATENDENDO
  } estado_leitor_t;

  // One-hot mask for a floor code; codes outside the served range give 0
  function automatic logic [N_ANDARES_MAX-1:0] mascara_andar(
    input logic [LARGURA_ANDAR-1:0] andar,
    input int                       n_andares
  );
    mascara_andar = '0;
    if (int'(andar) < n_andares)
      mascara_andar[andar] = 1'b1;
  endfunction

endpackage

// File: rtl/leitor_chamadas_if.sv
// Call-reader bus: switch/button requests and floor-controller feedback in,
// target floor, direction, hold and pending bitmap out.
interface leitor_chamadas_if;
  import elevador_pkg::*;

  logic [LARGURA_ANDAR-1:0] andar_atual;
  logic [LARGURA_ANDAR-1:0] andar_chamada;
  logic                     confirma_chamada;
  logic [LARGURA_ANDAR-1:0] andar_destino;
  logic                     confirma_destino;
  logic                     chegou;
  logic [LARGURA_ANDAR-1:0] andar_proximo;
  logic                     proximo_valido;
  logic                     subindo;
  logic                     parar_elevador;
  logic [N_ANDARES_MAX-1:0] pendentes;

  modport master (
    output andar_atual, andar_chamada, confirma_chamada,
    output andar_destino, confirma_destino, chegou,
    input  andar_proximo, proximo_valido, subindo,
    input  parar_elevador, pendentes
  );

  modport slave (
    input  andar_atual, andar_chamada, confirma_chamada,
    input  andar_destino, confirma_destino, chegou,
    output andar_proximo, proximo_valido, subindo,
    output parar_elevador, pendentes
  );

endinterface

// File: rtl/seletor_proximo_andar.sv
// Combinational search of the pending bitmap around the current floor.
// In: pendentes, andar_atual. Out: tem_acima/abaixo/atual, menor_acima, maior_abaixo.
module seletor_proximo_andar
  import elevador_pkg::*;
#(
  parameter int N_ANDARES = 4
) (
  input  logic [N_ANDARES_MAX-1:0] pendentes,
  input  logic [LARGURA_ANDAR-1:0] andar_atual,
  output logic                     tem_acima,
  output logic                     tem_abaixo,
  output logic                     tem_atual,
  output logic [LARGURA_ANDAR-1:0] menor_acima,
  output logic [LARGURA_ANDAR-1:0] maior_abaixo
);

  always_comb begin
    tem_acima    = 1'b0;
    tem_abaixo   = 1'b0;
    menor_acima  = '0;
    maior_abaixo = '0;
    // Scan downward so the last hit is the nearest floor above
    for (int i = N_ANDARES - 1; i >= 0; i--) begin
      if (pendentes[i] && i > int'(andar_atual)) begin
        tem_acima   = 1'b1;
        menor_acima = LARGURA_ANDAR'(i);
      end
    end
    // Scan upward so the last hit is the nearest floor below
    for (int i = 0; i < N_ANDARES; i++) begin
      if (pendentes[i] && i < int'(andar_atual)) begin
        tem_abaixo   = 1'b1;
        maior_abaixo = LARGURA_ANDAR'(i);
      end
    end
    tem_atual = |(pendentes & mascara_andar(andar_atual, N_ANDARES));
  end

endmodule

// File: rtl/leitor_chamadas.sv
// Pending-call store and direction-preserving sweep scheduler.
// Ports: clock_in, reset (async, active-high), bus (slave side of call bus).
module leitor_chamadas
  import elevador_pkg::*;
#(
  parameter int N_ANDARES = 4
) (
  input  logic              clock_in,
  input  logic              reset,
  leitor_chamadas_if.slave  bus
);

  estado_leitor_t           estado;
  logic [N_ANDARES_MAX-1:0] pendentes;
  logic                     dir;
  logic [LARGURA_ANDAR-1:0] proximo;
  logic                     valido;
  logic                     parar;

  logic                     tem_acima;
  logic                     tem_abaixo;
  logic                     tem_atual;
  logic [LARGURA_ANDAR-1:0] menor_acima;
  logic [LARGURA_ANDAR-1:0] maior_abaixo;

  logic [N_ANDARES_MAX-1:0] mascara_set;
  logic [N_ANDARES_MAX-1:0] mascara_clr;

  seletor_proximo_andar #(
    .N_ANDARES (N_ANDARES)
  ) u_seletor (
    .pendentes    (pendentes),
    .andar_atual  (bus.andar_atual),
    .tem_acima    (tem_acima),
    .tem_abaixo   (tem_abaixo),
    .tem_atual    (tem_atual),
    .menor_acima  (menor_acima),
    .maior_abaixo (maior_abaixo)
  );

  always_comb begin
    mascara_set = '0;
    mascara_clr = '0;
    if (bus.confirma_chamada)
      mascara_set = mascara_set
                  | mascara_andar(bus.andar_chamada, N_ANDARES);
    if (bus.confirma_destino)
      mascara_set = mascara_set
                  | mascara_andar(bus.andar_destino, N_ANDARES);
    if (bus.chegou && estado == ATENDENDO)
      mascara_clr = mascara_andar(bus.andar_atual, N_ANDARES);
  end

  // Clear applied after set: the door is already open at that floor
  always_ff @(posedge clock_in or posedge reset) begin
    if (reset)
      pendentes <= '0;
    else
      pendentes <= (pendentes | mascara_set) & ~mascara_clr;
  end

  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      estado  <= OCIOSO;
      dir     <= 1'b1;
      proximo <= '0;
      valido  <= 1'b0;
      parar   <= 1'b1;
    end else begin
      unique case (estado)
        OCIOSO, SUBINDO, DESCENDO: begin
          if (tem_atual) begin
            estado  <= ATENDENDO;
            proximo <= bus.andar_atual;
            valido  <= 1'b1;
            parar   <= 1'b1;
          end else if (tem_acima &&
                       (estado != DESCENDO || !tem_abaixo)) begin
            estado  <= SUBINDO;
            dir     <= 1'b1;
            proximo <= menor_acima;
            valido  <= 1'b1;
            parar   <= 1'b0;
          end else if (tem_abaixo) begin
            estado  <= DESCENDO;
            dir     <= 1'b0;
            proximo <= maior_abaixo;
            valido  <= 1'b1;
            parar   <= 1'b0;
          end else begin
            estado  <= OCIOSO;
            valido  <= 1'b0;
            parar   <= 1'b1;
          end
        end
        ATENDENDO: begin
          if (!bus.chegou) begin
            proximo <= bus.andar_atual;
          end else if (tem_acima && (dir || !tem_abaixo)) begin
            estado  <= SUBINDO;
            dir     <= 1'b1;
            proximo <= menor_acima;
            parar   <= 1'b0;
          end else if (tem_abaixo) begin
            estado  <= DESCENDO;
            dir     <= 1'b0;
            proximo <= maior_abaixo;
            parar   <= 1'b0;
          end else begin
            estado  <= OCIOSO;
            valido  <= 1'b0;
          end
        end
        default: estado <= OCIOSO;
      endcase
    end
  end

  assign bus.pendentes      = pendentes;
  assign bus.subindo        = dir;
  assign bus.andar_proximo  = proximo;
  assign bus.proximo_valido = valido;
  assign bus.parar_elevador = parar;

endmodule

// File: tb/tb_leitor_chamadas.sv
// Directed bench for leitor_chamadas: 4-floor and 3-floor instances.
// Drives calls, floor changes and arrivals; checks registered outputs.
module tb_leitor_chamadas;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_erros;

  leitor_chamadas_if b ();
  leitor_chamadas_if b3 ();

  leitor_chamadas #(.N_ANDARES(4)) dut (
    .clock_in (clk),
    .reset    (reset),
    .bus      (b)
  );

  leitor_chamadas #(.N_ANDARES(3)) dut3 (
    .clock_in (clk),
    .reset    (reset),
    .bus      (b3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_erros++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pulso_reset;
    reset = 1'b1;
    #1;
    reset = 1'b0;
  endtask

  task automatic solta;
    b.confirma_chamada  = 1'b0;
    b.confirma_destino  = 1'b0;
    b.chegou            = 1'b0;
    b3.confirma_chamada = 1'b0;
    b3.confirma_destino = 1'b0;
    b3.chegou           = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_erros  = 0;
    reset    = 1'b1;
    b.andar_atual   = 2'd0;
    b.andar_chamada = 2'd0;
    b.andar_destino = 2'd0;
    b3.andar_atual   = 2'd0;
    b3.andar_chamada = 2'd0;
    b3.andar_destino = 2'd0;
    solta();
    #3;
    chk("rst_pend",   b.pendentes,      4'b0000);
    chk("rst_prox",   b.andar_proximo,  2'd0);
    chk("rst_valido", b.proximo_valido, 1'b0);
    chk("rst_sobe",   b.subindo,        1'b1);
    chk("rst_parar",  b.parar_elevador, 1'b1);
    reset = 1'b0;

    // Single hall call above
    b.andar_chamada = 2'd2;
    b.confirma_chamada = 1'b1;
    tick();
    solta();
    chk("t1_pend",   b.pendentes,      4'b0100);
    chk("t1_val0",   b.proximo_valido, 1'b0);
    tick();
    chk("t1_prox",   b.andar_proximo,  2'd2);
    chk("t1_valido", b.proximo_valido, 1'b1);
    chk("t1_parar",  b.parar_elevador, 1'b0);
    chk("t1_sobe",   b.subindo,        1'b1);
    b.confirma_chamada = 1'b1;
    tick();
    solta();
    chk("t1_repete", b.pendentes,      4'b0100);

    // Calls 1 and 3, stop at 1, continue up to 3
    pulso_reset();
    b.andar_atual = 2'd0;
    b.andar_chamada = 2'd1;
    b.andar_destino = 2'd3;
    b.confirma_chamada = 1'b1;
    b.confirma_destino = 1'b1;
    tick();
    solta();
    chk("t2_pend",  b.pendentes,     4'b1010);
    tick();
    chk("t2_prox1", b.andar_proximo, 2'd1);
    b.andar_atual = 2'd1;
    tick();
    chk("t2_parar", b.parar_elevador, 1'b1);
    chk("t2_aqui",  b.andar_proximo,  2'd1);
    b.chegou = 1'b1;
    tick();
    solta();
    chk("t2_pend2", b.pendentes,      4'b1000);
    chk("t2_prox3", b.andar_proximo,  2'd3);
    chk("t2_sobe",  b.subindo,        1'b1);
    chk("t2_anda",  b.parar_elevador, 1'b0);

    // At 2 moving up with {0,3}: serve 3 first, then reverse
    b.andar_chamada = 2'd0;
    b.confirma_chamada = 1'b1;
    b.andar_atual = 2'd2;
    tick();
    solta();
    chk("t3_pend",  b.pendentes,     4'b1001);
    tick();
    chk("t3_prox",  b.andar_proximo, 2'd3);
    chk("t3_sobe",  b.subindo,       1'b1);
    b.andar_atual = 2'd3;
    tick();
    chk("t3_parar", b.parar_elevador, 1'b1);
    b.chegou = 1'b1;
    tick();
    solta();
    chk("t3_pend2", b.pendentes,      4'b0001);
    chk("t3_desce", b.subindo,        1'b0);
    chk("t3_prox0", b.andar_proximo,  2'd0);
    chk("t3_anda",  b.parar_elevador, 1'b0);
    b.andar_atual = 2'd0;
    tick();
    chk("t3_para0", b.parar_elevador, 1'b1);
    b.chegou = 1'b1;
    tick();
    solta();
    chk("t3_vazio", b.pendentes,      4'b0000);
    chk("t3_ocio",  b.proximo_valido, 1'b0);
    chk("t3_ocio_p", b.parar_elevador, 1'b1);

    // Clear wins over same-cycle set at the open door
    pulso_reset();
    b.andar_atual = 2'd1;
    b.andar_destino = 2'd1;
    b.confirma_destino = 1'b1;
    tick();
    solta();
    chk("t4_pend",   b.pendentes,      4'b0010);
    tick();
    chk("t4_parar",  b.parar_elevador, 1'b1);
    chk("t4_valido", b.proximo_valido, 1'b1);
    chk("t4_prox",   b.andar_proximo,  2'd1);
    b.chegou = 1'b1;
    b.confirma_destino = 1'b1;
    tick();
    solta();
    chk("t4_clr",    b.pendentes,      4'b0000);
    chk("t4_ocio",   b.proximo_valido, 1'b0);

    // Three-floor instance: code 3 ignored, dual confirm sets both
    b3.andar_chamada = 2'd3;
    b3.confirma_chamada = 1'b1;
    tick();
    solta();
    chk("t5_fora",  b3.pendentes, 4'b0000);
    b3.andar_chamada = 2'd0;
    b3.andar_destino = 2'd2;
    b3.confirma_chamada = 1'b1;
    b3.confirma_destino = 1'b1;
    tick();
    solta();
    chk("t5_dois",  b3.pendentes, 4'b0101);

    // Reset in the middle of a downward sweep
    pulso_reset();
    b.andar_atual = 2'd2;
    b.andar_destino = 2'd1;
    b.confirma_destino = 1'b1;
    tick();
    solta();
    tick();
    b.andar_chamada = 2'd3;
    b.confirma_chamada = 1'b1;
    tick();
    solta();
    chk("t6_pend",   b.pendentes,      4'b1010);
    chk("t6_desce",  b.subindo,        1'b0);
    chk("t6_prox",   b.andar_proximo,  2'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("t6_rpend",  b.pendentes,      4'b0000);
    chk("t6_rsobe",  b.subindo,        1'b1);
    chk("t6_rparar", b.parar_elevador, 1'b1);
    chk("t6_rval",   b.proximo_valido, 1'b0);
    chk("t6_rprox",  b.andar_proximo,  2'd0);
    reset = 1'b0;
    b.andar_chamada = 2'd0;
    b.confirma_chamada = 1'b1;
    tick();
    solta();
    chk("t6_novo",   b.pendentes,      4'b0001);
    tick();
    chk("t6_nprox",  b.andar_proximo,  2'd0);
    chk("t6_ndesce", b.subindo,        1'b0);
    chk("t6_nval",   b.proximo_valido, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_erros);
    $finish;
  end

endmodule
